// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt acknowledge sequencer.
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    P_LOW,
    P_GAP,
    DONE
  } inta_state_t;

  localparam logic       MODE_8080   = 1'b0;
  localparam logic       MODE_8086   = 1'b1;
  localparam logic [7:0] OPCODE_CALL = 8'hCD;

endpackage

// File: rtl/int_synchronizer.sv
// Two-flop synchroniser for the asynchronous INT line; only built when
// INTA_SYNC_EN is defined.
`ifdef INTA_SYNC_EN
module int_synchronizer (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`endif

// File: rtl/inta_sequencer.sv
// CPU-side INT/INTA acknowledge sequencer (8086 two-pulse / 8080 three-pulse).
// Define INTA_SYNC_EN to pass INT through a two-flop synchroniser.
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int PULSE_LOW = 4,
  parameter int PULSE_GAP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        INT,
  input  logic        IF,
  input  logic        mode8086,
  input  logic [7:0]  D,
  output logic        INTA_n,
  output logic [7:0]  vector,
  output logic [15:0] call_addr,
  output logic [7:0]  opcode,
  output logic        vector_valid,
  input  logic        vector_ready
);

  localparam int CNT_MAX = (PULSE_LOW > PULSE_GAP) ? PULSE_LOW : PULSE_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LOW_LOAD = CW'(PULSE_LOW - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(PULSE_GAP - 1);

  logic int_s;

`ifdef INTA_SYNC_EN
  int_synchronizer u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (INT),
    .q     (int_s)
  );
`else
  assign int_s = INT;
`endif

  inta_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          mode_q, mode_d;
  logic          capture;
  logic          last_pulse;

  assign last_pulse = (mode_q == MODE_8086) ? (idx_q == 2'd1) : (idx_q == 2'd2);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (int_s && IF) begin
          mode_d  = mode8086;
          idx_d   = 2'd0;
          cnt_d   = LOW_LOAD;
          state_d = P_LOW;
        end
      end
      P_LOW: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          if (last_pulse) begin
            state_d = DONE;
          end else begin
            cnt_d   = GAP_LOAD;
            state_d = P_GAP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      P_GAP: begin
        if (cnt_q == '0) begin
          idx_d   = idx_q + 2'd1;
          cnt_d   = LOW_LOAD;
          state_d = P_LOW;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (vector_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      mode_q  <= MODE_8080;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
    end
  end

  // Strobe and valid are registered from the next state so they are
  // glitch-free yet track the state without a cycle of lag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      INTA_n       <= 1'b1;
      vector_valid <= 1'b0;
    end else begin
      INTA_n       <= (state_d != P_LOW);
      vector_valid <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vector    <= 8'h00;
      opcode    <= 8'h00;
      call_addr <= 16'h0000;
    end else if (capture) begin
      if (mode_q == MODE_8086) begin
        if (idx_q == 2'd1) vector <= D;
      end else begin
        case (idx_q)
          2'd0:    opcode          <= D;
          2'd1:    call_addr[7:0]  <= D;
          2'd2:    call_addr[15:8] <= D;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed, table-driven bench for inta_sequencer.
module tb_inta_sequencer;
  import pic_pkg::*;

  localparam int PL = 4;
  localparam int PG = 2;
`ifdef INTA_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        reset;
  logic        INT;
  logic        IF;
  logic        mode8086;
  logic [7:0]  D;
  logic        INTA_n;
  logic [7:0]  vector;
  logic [15:0] call_addr;
  logic [7:0]  opcode;
  logic        vector_valid;
  logic        vector_ready;

  inta_sequencer #(.PULSE_LOW(PL), .PULSE_GAP(PG)) dut (
    .clk          (clk),
    .reset        (reset),
    .INT          (INT),
    .IF           (IF),
    .mode8086     (mode8086),
    .D            (D),
    .INTA_n       (INTA_n),
    .vector       (vector),
    .call_addr    (call_addr),
    .opcode       (opcode),
    .vector_valid (vector_valid),
    .vector_ready (vector_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       mode;
    logic [7:0] d0, d1, d2;
    int         ready_delay;
    logic [7:0] exp_vec;
    logic [7:0] exp_op;
    logic [15:0] exp_call;
  } vec_t;

  vec_t tbl[4];

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, " vector"}, 32'(vector), 32'(v.exp_vec));
    check({tag, " opcode"}, 32'(opcode), 32'(v.exp_op));
    check({tag, " call_addr"}, 32'(call_addr), 32'(v.exp_call));
  endtask

  task automatic run_seq(input vec_t v, input int row);
    logic [7:0] dbytes[3];
    int npulse, lowc, gapc, total, lat;
    string tag;
    tag    = $sformatf("row%0d", row);
    dbytes = '{v.d0, v.d1, v.d2};
    npulse = v.mode ? 2 : 3;
    mode8086     = v.mode;
    D            = v.d0;
    vector_ready = (v.ready_delay == 0);
    IF           = 1'b1;
    INT          = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (INTA_n !== 1'b0 && lat < 20);
    check({tag, " latency"}, 32'(lat), 32'(LAT));
    INT   = 1'b0;
    total = 0;
    for (int p = 0; p < npulse; p++) begin
      D    = dbytes[p];
      lowc = 0;
      while (INTA_n === 1'b0 && lowc < 50) begin
        tick();
        lowc++;
      end
      total += lowc;
      check($sformatf("%s pulse%0d low width", tag, p), 32'(lowc), 32'(PL));
      if (p < npulse - 1) begin
        gapc = 0;
        while (INTA_n === 1'b1 && vector_valid !== 1'b1 && gapc < 50) begin
          tick();
          gapc++;
        end
        total += gapc;
        check($sformatf("%s gap%0d width", tag, p), 32'(gapc), 32'(PG));
      end
    end
    check({tag, " cycles to valid"}, 32'(total), 32'(v.mode ? 2*PL + PG : 3*PL + 2*PG));
    check({tag, " valid"}, 32'(vector_valid), 32'd1);
    if (v.ready_delay == 0) begin
      check_outputs(tag, v);
      tick();
      check({tag, " valid one cycle"}, 32'(vector_valid), 32'd0);
    end else begin
      D = 8'hFF;
      repeat (v.ready_delay) tick();
      check({tag, " valid held"}, 32'(vector_valid), 32'd1);
      check({tag, " strobe idle in done"}, 32'(INTA_n), 32'd1);
      check_outputs({tag, " stalled"}, v);
      vector_ready = 1'b1;
      tick();
      check({tag, " valid after accept"}, 32'(vector_valid), 32'd0);
    end
    check_outputs({tag, " final"}, v);
    vector_ready = 1'b0;
    repeat (2) tick();
    check({tag, " idle strobe"}, 32'(INTA_n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad;

    // Expected values are cumulative: registers not written by a row keep
    // the value left by earlier rows.
    tbl[0] = '{1'b1, 8'h00, 8'h48, 8'h00, 0, 8'h48, 8'h00, 16'h0000};
    tbl[1] = '{1'b0, 8'hCD, 8'h00, 8'h20, 0, 8'h48, OPCODE_CALL, 16'h2000};
    tbl[2] = '{1'b1, 8'h11, 8'hA5, 8'h00, 5, 8'hA5, OPCODE_CALL, 16'h2000};
    tbl[3] = '{1'b0, 8'hCD, 8'h34, 8'h12, 2, 8'hA5, OPCODE_CALL, 16'h1234};

    reset = 1'b1; INT = 1'b0; IF = 1'b0; mode8086 = 1'b1;
    D = 8'h00; vector_ready = 1'b0;
    #2;
    check("reset INTA_n", 32'(INTA_n), 32'd1);
    check("reset vector", 32'(vector), 32'h00);
    check("reset opcode", 32'(opcode), 32'h00);
    check("reset call_addr", 32'(call_addr), 32'h0000);
    check("reset valid", 32'(vector_valid), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();

    for (int r = 0; r < 4; r++) run_seq(tbl[r], r);

    // IF low blocks the request indefinitely; raising it starts at once.
    IF = 1'b0; INT = 1'b1; mode8086 = 1'b1; D = 8'h5A;
    bad = 0;
    repeat (20) begin
      tick();
      if (INTA_n !== 1'b1) bad++;
    end
    check("IF=0 holds INTA_n high", 32'(bad), 32'd0);
    IF = 1'b1;
    vector_ready = 1'b1;
    tick();
    check("IF rise starts next edge", 32'(INTA_n), 32'd0);
    INT = 1'b0;
    n = 0;
    while (vector_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("IF seq valid", 32'(vector_valid), 32'd1);
    check("IF seq vector", 32'(vector), 32'h5A);
    tick();
    vector_ready = 1'b0;
    check("IF seq back to idle", 32'(vector_valid), 32'd0);
    repeat (2) tick();

    // Reset during the second low pulse of an 8080 sequence.
    mode8086 = 1'b0; IF = 1'b1; INT = 1'b1; D = 8'h77;
    n = 0;
    while (INTA_n !== 1'b0 && n < 20) begin tick(); n++; end
    INT = 1'b0;
    while (INTA_n !== 1'b1 && n < 40) begin tick(); n++; end
    while (INTA_n !== 1'b0 && n < 60) begin tick(); n++; end
    check("reached second pulse", 32'(INTA_n), 32'd0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("mid reset INTA_n", 32'(INTA_n), 32'd1);
    check("mid reset vector", 32'(vector), 32'h00);
    check("mid reset opcode", 32'(opcode), 32'h00);
    check("mid reset call_addr", 32'(call_addr), 32'h0000);
    check("mid reset valid", 32'(vector_valid), 32'd0);
    tick();
    reset = 1'b0;
    bad = 0;
    repeat (30) begin
      tick();
      if (vector_valid !== 1'b0 || INTA_n !== 1'b1) bad++;
    end
    check("no valid after reset", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
